pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//   Sequences the Ethernet PLL: drives its reset, waits for lock with a timeout, and qualifies
//   lock as stable before releasing the downstream Ethernet reset. On timeout or lock loss it
//   re-resets the PLL with bounded retries, then raises a sticky fail flag. Runs on the free-running
//   50 MHz init clock (20 ns). Sits between the PLL wrapper and the MAC/PHY reset tree.
// PARAMETERS
//   RST_CYCLES     16     cycles pll_rst is held high per attempt (>=1)
//   LOCK_TIMEOUT   50000  cycles allowed from pll_rst release to first synced lock (1 ms)
//   STABLE_CYCLES  1024   consecutive synced-lock cycles required before release (>=1)
//   MAX_RETRY      3      re-attempts after the first; total attempts = MAX_RETRY+1 (<=15)
//   CNT_W          16     timer width; every cycle parameter must be < 2**CNT_W
// PORTS
//   init_clk   in   1  free-running 50 MHz clock; all logic on its rising edge
//   reset_n    in   1  asynchronous active-low reset
//   enable     in   1  1 = run sequence; 0 = force IDLE
//   pll_lock   in   1  PLL lock, asynchronous to init_clk
//   pll_rst    out  1  PLL reset, active-high
//   sys_rst_n  out  1  downstream reset, active-low, high only in RUN
//   locked     out  1  1 only in RUN
//   fail       out  1  sticky, 1 only in FAIL
//   retry_cnt  out  4  re-attempts used since last enable rise; saturates at MAX_RETRY
// BEHAVIOUR
//   Reset: pll_rst=1, sys_rst_n=0, locked=0, fail=0, retry_cnt=0, state=IDLE, timer=0.
//   pll_lock passes a 2-FF synchroniser (lock_s); decisions use lock_s only (2-cycle latency).
//   All outputs registered, decoded from state: pll_rst=1 in IDLE/RESET/FAIL; sys_rst_n=locked=(RUN).
//   timer clears on every state entry and counts +1 per cycle while in RESET/WAIT_LOCK/STABLE.
//   States/transitions (enable=0 in any state -> IDLE next cycle; has priority over all below):
//     IDLE:      enable=1 -> RESET, retry_cnt<=0.
//     RESET:     timer==RST_CYCLES-1 -> WAIT_LOCK.
//     WAIT_LOCK: lock_s=1 -> STABLE; else timer==LOCK_TIMEOUT-1 -> RETRY event.
//     STABLE:    lock_s=0 -> WAIT_LOCK (timer restarts, timeout window restarts; no retry used);
//                timer==STABLE_CYCLES-1 with lock_s=1 -> RUN.
//     RUN:       lock_s=0 -> RETRY event; sys_rst_n low the cycle after lock_s falls.
//     FAIL:      held until enable=0 or reset_n=0.
//   RETRY event: retry_cnt<MAX_RETRY -> retry_cnt+1, RESET; retry_cnt==MAX_RETRY -> FAIL,
//     retry_cnt unchanged. Timeout and lock loss share the same retry budget.
//   Simultaneous: timer terminal and lock_s rise in WAIT_LOCK -> lock wins (STABLE).
//   enable toggling 1->0->1 re-starts from RESET with retry_cnt=0 and fail cleared.
//   reset_n asserted mid-sequence: immediate return to reset values (pll_rst high asynchronously).
// STRUCTURE
//   Shared package pll_sup_pkg: 3-bit state encoding (IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3,
//   RUN=4, FAIL=5) and default cycle constants, reused by the bench and status readback.
//   One sub-module: sync_2ff (generic 2-flop synchroniser, async active-low reset, resets to 0).
//   FSM, timer and retry counter stay in this module.
// TESTING
//   1 Lock 100 cycles after pll_rst falls, held -> pll_rst low after 16 cycles, sys_rst_n=1 and
//     locked=1 exactly 16+100+2+1024 (+/-1 registration) cycles after enable; retry_cnt=0.
//   2 pll_lock never asserts -> 4 attempts, each 16 high + 50000 low on pll_rst; then fail=1,
//     retry_cnt=3, pll_rst=1, sys_rst_n=0 held indefinitely.
//   3 Lock drops for 5 cycles at STABLE cycle 500 -> returns to WAIT_LOCK, retry_cnt stays 0,
//     release 1024 cycles after lock re-stabilises.
//   4 Lock lost in RUN -> sys_rst_n=0 within 3 cycles of pll_lock fall, pll_rst pulses 16 cycles,
//     retry_cnt=1; re-lock -> RUN again.
//   5 enable=0 during WAIT_LOCK, then in FAIL -> IDLE next cycle, pll_rst=1, fail=0; enable=1
//     restarts with retry_cnt=0.
//   6 reset_n pulsed low mid-RUN (asynchronous to clock) -> all outputs at reset values before
//     the next edge; sequence restarts when reset_n returns high with enable=1.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
// pll_sup_pkg: state encoding and default cycle constants for the PLL lock supervisor.
// Rev 1.0
`default_nettype none

package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_CNT_W         = 16;

  // States in which the timer advances; every other state holds it at zero.
  function automatic logic timer_active(pll_state_e s);
    return (s == ST_RESET) || (s == ST_WAIT_LOCK) || (s == ST_STABLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser with asynchronous active-low reset to zero.
// Rev 1.0
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: resets the Ethernet PLL, qualifies lock, retries a bounded number of times.
// Rev 1.0
`default_nettype none

module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       init_clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  logic             lock_s;
  pll_state_e       state;
  pll_state_e       state_nx;
  logic [CNT_W-1:0] timer;
  logic [3:0]       retry_nx;
  logic             retry_ev;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (init_clk),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    retry_ev = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nx = ST_RESET;
          retry_nx = 4'd0;
        end
      end
      ST_RESET: begin
        if (timer == RST_LAST) state_nx = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock arriving on the terminal cycle still wins over the timeout.
        if (lock_s)                     state_nx = ST_STABLE;
        else if (timer == TIMEOUT_LAST) retry_ev = 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s)                   state_nx = ST_WAIT_LOCK;
        else if (timer == STABLE_LAST) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) retry_ev = 1'b1;
      end
      ST_FAIL: ;
      default: state_nx = ST_IDLE;
    endcase

    // Timeout and lock loss draw on one shared retry budget.
    if (retry_ev) begin
      if (retry_cnt < RETRY_MAX) begin
        retry_nx = retry_cnt + 4'd1;
        state_nx = ST_RESET;
      end else begin
        state_nx = ST_FAIL;
      end
    end

    if (!enable) begin
      state_nx = ST_IDLE;
      retry_nx = retry_cnt;
    end
  end

  always_ff @(posedge init_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      retry_cnt <= 4'd0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nx;
      retry_cnt <= retry_nx;
      if (state_nx != state)    timer <= '0;
      else if (timer_active(state)) timer <= timer + 1'b1;
      // Outputs are decoded from the next state so they switch on the same edge as the state.
      pll_rst   <= (state_nx == ST_IDLE) || (state_nx == ST_RESET) || (state_nx == ST_FAIL);
      sys_rst_n <= (state_nx == ST_RUN);
      locked    <= (state_nx == ST_RUN);
      fail      <= (state_nx == ST_FAIL);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scoreboard bench with an interval-based model of the lock supervisor.
// Rev 1.0
`default_nettype none

module tb_pll_lock_supervisor;

  localparam int R    = 16;
  localparam int T    = 400;
  localparam int SC   = 200;
  localparam int MAXR = 3;
  localparam logic [7:0] RST_V = 8'b1000_0000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       pll_lock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;

  pll_lock_supervisor #(
    .RST_CYCLES    (R),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (SC),
    .MAX_RETRY     (MAXR),
    .CNT_W         (16)
  ) dut (
    .init_clk  (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pll_lock  (pll_lock),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected output-vector changes {pll_rst,sys_rst_n,locked,fail,retry_cnt} with edge index.
  int         exp_t[$];
  logic [7:0] exp_v[$];
  logic [7:0] m_vec;
  bit         lockv[];
  int         g_b;
  int         g_h;

  function automatic logic [7:0] mk(bit p, bit s, bit f, int rc);
    return {p, s, s, f, 4'(rc)};
  endfunction

  function automatic void push_ev(int t, logic [7:0] v, int lim);
    if (t < lim && v !== m_vec) begin
      exp_t.push_back(t);
      exp_v.push_back(v);
      m_vec = v;
    end
  endfunction

  // Synchronised lock value the controller acts on at edge k (pin value driven after edge k-3).
  function automatic bit seen(int k);
    int idx = k - 3 - g_b;
    return (idx >= 0 && idx < g_h) ? lockv[idx] : 1'b0;
  endfunction

  function automatic int first_seen(int lo, int hi, bit val, int lim);
    int top = (hi < lim) ? hi : lim - 1;
    for (int k = lo; k <= top; k++) if (seen(k) == val) return k;
    return -1;
  endfunction

  // Enable sampled at edge b+1; disable (or reset) takes effect at edge b+h.
  task automatic predict(input int b, input int h, input bit rst_end);
    int x = b + h;
    int t = b + 1;
    int rc = 0;
    int w, k, s, r, ra;
    bit go = 1'b1;
    push_ev(t, mk(1, 0, 0, 0), x);
    while (go) begin
      if (t + R >= x) break;
      push_ev(t + R, mk(0, 0, 0, rc), x);
      w = t + R; ra = -1; r = -1;
      while (ra < 0 && r < 0) begin
        k = first_seen(w + 1, w + T, 1'b1, x);
        if (k < 0) ra = w + T;
        else begin
          s = k;
          k = first_seen(s + 1, s + SC, 1'b0, x);
          if (k < 0) r = s + SC;
          else       w = k;
        end
      end
      if (r >= 0) begin
        if (r >= x) break;
        push_ev(r, mk(0, 1, 0, rc), x);
        ra = first_seen(r + 1, x - 1, 1'b0, x);
        if (ra < 0) break;
      end
      if (ra >= x) break;
      if (rc < MAXR) begin
        rc++;
        push_ev(ra, mk(1, 0, 0, rc), x);
        t = ra;
      end else begin
        push_ev(ra, mk(1, 0, 1, rc), x);
        go = 1'b0;
      end
    end
    push_ev(x, rst_end ? RST_V : mk(1, 0, 0, rc), x + 1);
  endtask

  task automatic make_wave(input int h, input int first_hi, input int drop_at, input int drop_len);
    lockv = new[h];
    for (int i = 0; i < h; i++)
      lockv[i] = (i >= first_hi) && !(i >= drop_at && i < drop_at + drop_len);
  endtask

  task automatic make_rand(input int h);
    int i = 0;
    int len;
    bit v = 1'b0;
    lockv = new[h];
    while (i < h) begin
      if (!v) len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6)  : $urandom_range(20, 1200);
      else    len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : $urandom_range(150, 1500);
      for (int j = 0; j < len && i < h; j++) begin
        lockv[i] = v;
        i++;
      end
      v = ~v;
    end
  endtask

  task automatic run_scenario(input int h, input bit rst_end);
    int b = cyc;
    g_b = b;
    g_h = h;
    predict(b, h, rst_end);
    for (int i = 0; i < h; i++) begin
      pll_lock = lockv[i];
      reset_n  = 1'b1;
      enable   = (i < h - 1) || rst_end;
      if (i == h - 1 && rst_end) begin
        #4 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({pll_rst, sys_rst_n, locked, fail, retry_cnt} !== RST_V) begin
          n_fail++;
          $display("FAIL async_reset cyc=%0d got=%b expected=%b", cyc,
                   {pll_rst, sys_rst_n, locked, fail, retry_cnt}, RST_V);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      pll_lock = 1'b0;
      enable   = rst_end;
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every change of the output vector must match the next scoreboard entry.
  bit         mon_on = 1'b0;
  logic [7:0] prev_v;
  logic [7:0] cur_v;
  int         et;
  logic [7:0] ev;
  always @(posedge clk) begin
    #2;
    if (mon_on) begin
      cur_v = {pll_rst, sys_rst_n, locked, fail, retry_cnt};
      if (cur_v !== prev_v) begin
        n_tests++;
        if (exp_t.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%b expected no change", cyc, cur_v);
        end else begin
          et = exp_t.pop_front();
          ev = exp_v.pop_front();
          if (et != cyc || ev !== cur_v) begin
            n_fail++;
            $display("FAIL output_event got=%b at cyc %0d expected=%b at cyc %0d", cur_v, cyc, ev, et);
          end
        end
        prev_v = cur_v;
      end
    end
  end

  initial begin
    #2_100_000;
    $display("FAIL watchdog cyc=%0d expected completion before time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    pll_lock = 1'b0;
    m_vec    = RST_V;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    n_tests++;
    if ({pll_rst, sys_rst_n, locked, fail, retry_cnt} !== RST_V) begin
      n_fail++;
      $display("FAIL reset_values got=%b expected=%b", {pll_rst, sys_rst_n, locked, fail, retry_cnt}, RST_V);
    end
    reset_n = 1'b1;
    prev_v  = RST_V;
    mon_on  = 1'b1;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end

    make_wave(1500, 117, 0, 0);           run_scenario(1500, 1'b0); // lock 100 after pll_rst falls
    make_wave(2000, 2000, 0, 0);          run_scenario(2000, 1'b0); // never locks -> fail
    make_wave(1000, 117, 217, 5);         run_scenario(1000, 1'b0); // glitch while stable
    make_wave(1200, 117, 400, 40);        run_scenario(1200, 1'b0); // loss in run, re-lock
    make_wave(60, 60, 0, 0);              run_scenario(60, 1'b0);   // disable during wait
    make_wave(800, 414, 0, 0);            run_scenario(800, 1'b0);  // lock on terminal cycle
    make_wave(1200, 415, 0, 0);           run_scenario(1200, 1'b0); // lock one cycle late
    make_wave(500, 117, 0, 0);            run_scenario(500, 1'b1);  // reset_n pulsed in run
    make_wave(1500, 117, 0, 0);           run_scenario(1500, 1'b0); // restart after reset

    for (int n = 0; n < 12; n++) begin
      int h = $urandom_range(1200, 3500);
      make_rand(h);
      run_scenario(h, 1'b0);
    end

    n_tests++;
    if (exp_t.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got=%0d left expected=0 (next at cyc %0d)", exp_t.size(), exp_t[0]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
